reg_share_arbiter: RTL



---
 rtl/reg_share_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin arbiter sharing one register among requesters
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic                     wr_stb
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [IDX_W-1:0] winner;
  logic             found;
  int               sel_idx;
  logic [WIDTH-1:0] owner_data;
  logic             owner_req;
  logic             stay;
  logic [IDX_W-1:0] next_ptr;

  // Complementary output is derived from q so the two can never disagree.
  assign qbar = ~q;

  // Rotating priority search: first requester at or after ptr, wrapping.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    sel_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[sel_idx]) begin
        winner = IDX_W'(sel_idx);
        found  = 1'b1;
      end
    end
  end

  // Current grantee's request/data and the keep-or-release decision.
  always_comb begin
    owner_data = wdata[int'(owner)*WIDTH +: WIDTH];
    owner_req  = req[owner];
    stay       = owner_req && lock[owner] && (int'(hold_cnt) < MAX_HOLD - 1);
    next_ptr   = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM plus the shared storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      wr_stb   <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= N_REQ'(1) << winner;
            owner    <= winner;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (owner_req) begin
            q      <= owner_data;
            wr_stb <= 1'b1;
          end
          if (stay) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            gnt   <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
